// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with configurable data width, parity and stop
// bits, plus a one-word holding register so frames can run back-to-back.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | line high, waiting for the holding register to fill
//   S_START  | start bit (0) on the line
//   S_DATA   | data bits, LSB first; r_bit_idx counts the bits
//   S_PARITY | parity bit (only when PARITY != 0)
//   S_STOP   | stop bit(s); r_bit_idx counts them; reload from buffer at end
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 256,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int PAR_W   = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_W = 1 + DATA_BITS + PAR_W + STOP_BITS;
  localparam int IDX_W   = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_tx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [FRAME_W-1:0]   r_frame;
  logic [FRAME_W-1:0]   w_frame_nxt;
  logic [FRAME_W-1:0]   w_frame_load;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_buf_valid;
  logic                 r_ready;
  logic                 r_serial;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_parity;
  logic                 w_serial_nxt;
  logic                 w_done;

  // The bit timer is a down-counter; a bit period ends when it reaches zero.
  assign w_tick      = (r_state != S_IDLE) && (r_clk_cnt == '0);
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_bit_idx == STOP_LAST);
  assign w_load      = r_buf_valid && ((r_state == S_IDLE) || w_last_stop);
  assign w_accept    = i_Tx_DV && r_ready;
  assign w_parity    = (^r_buf) ^ (PARITY == 1);

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_buf_valid) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick && (r_bit_idx == DATA_LAST))
                  w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_last_stop) w_state_nxt = r_buf_valid ? S_START : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: the whole frame is a shift register whose LSB is the line
  // value, refilled with ones so the stop bits fall out naturally.
  always_comb begin
    w_frame_load               = '1;
    w_frame_load[0]            = 1'b0;
    w_frame_load[DATA_BITS:1]  = r_buf;
    if (PARITY != 0) w_frame_load[DATA_BITS+1] = w_parity;
    if (w_load)      w_frame_nxt = w_frame_load;
    else if (w_tick) w_frame_nxt = {1'b1, r_frame[FRAME_W-1:1]};
    else             w_frame_nxt = r_frame;
    w_serial_nxt = (w_state_nxt == S_IDLE) ? 1'b1 : w_frame_nxt[0];
    w_done       = w_last_stop;
  end

  // Bit timer, bit index, frame shifter and the registered serial line.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_frame   <= '1;
      r_serial  <= 1'b1;
    end else begin
      r_frame  <= w_frame_nxt;
      r_serial <= w_serial_nxt;
      if (w_state_nxt == S_IDLE)  r_clk_cnt <= '0;
      else if (w_load || w_tick)  r_clk_cnt <= CNT_LOAD;
      else                        r_clk_cnt <= r_clk_cnt - 1'b1;
      if (w_state_nxt != r_state) r_bit_idx <= '0;
      else if (w_tick)            r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Holding register; accept and drain can never coincide since they need
  // opposite occupancy.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_buf_valid <= 1'b0;
      r_ready     <= 1'b1;
      r_buf       <= '0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
      r_ready     <= 1'b0;
      r_buf       <= i_Tx_Data;
    end else if (w_load) begin
      r_buf_valid <= 1'b0;
      r_ready     <= 1'b1;
    end
  end

  assign o_Tx_Ready  = r_ready;
  assign o_Tx_Active = (r_state != S_IDLE);
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = w_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations side by side, each checked every
// cycle against a frame-level model, plus directed literal expectations.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv [4];
  logic [8:0] tx_data [4];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         chk_en   = 1'b0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Line bits of one frame, index = bit position on the wire.
  function automatic logic [15:0] make_frame(input logic [8:0] d, input int db, input int pm);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (pm == 1)      f[db+1] = (ones % 2 == 0);
    else if (pm == 2) f[db+1] = (ones % 2 == 1);
    return f;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int CPB = (g == 3) ? 3 : 4;
    localparam int DB  = (g == 3) ? 7 : 8;
    localparam int PM  = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int SB  = (g >= 2) ? 2 : 1;
    localparam int FL  = CPB * (1 + DB + ((PM != 0) ? 1 : 0) + SB);

    logic o_ready, o_active, o_serial, o_done;

    uart_tx_cfg #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (PM),
      .STOP_BITS   (SB)
    ) u_dut (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Tx_DV    (dv[g]),
      .i_Tx_Data  (tx_data[g][DB-1:0]),
      .o_Tx_Ready (o_ready),
      .o_Tx_Active(o_active),
      .o_Tx_Serial(o_serial),
      .o_Tx_Done  (o_done)
    );

    bit          m_bv, m_busy, m_acc;
    logic [8:0]  m_buf;
    logic [15:0] m_bits;
    int          m_pos;

    // Model: a buffer slot and a frame in flight indexed by cycle position.
    initial begin
      m_bv = 0; m_busy = 0; m_pos = 0; m_buf = '0; m_bits = '1;
      forever begin
        @(posedge clk);
        if (rst) begin
          m_bv = 0; m_busy = 0; m_pos = 0;
        end else begin
          m_acc = dv[g] && !m_bv;
          if (m_busy) begin
            m_pos++;
            if (m_pos == FL) begin
              m_pos = 0;
              if (m_bv) begin
                m_bits = make_frame(m_buf, DB, PM);
                m_bv   = 0;
              end else begin
                m_busy = 0;
              end
            end
          end else if (m_bv) begin
            m_bits = make_frame(m_buf, DB, PM);
            m_bv   = 0;
            m_busy = 1;
            m_pos  = 0;
          end
          if (m_acc) begin
            m_bv  = 1;
            m_buf = tx_data[g];
          end
        end
      end
    end

    // Compare every cycle on the falling edge.
    initial begin
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("serial", g, o_serial, m_busy ? m_bits[m_pos / CPB] : 1'b1);
          check("ready",  g, o_ready,  !m_bv);
          check("active", g, o_active, m_busy);
          check("done",   g, o_done,   m_busy && (m_pos == FL - 1));
        end
      end
    end
  end

  initial begin
    int          n_done, k_done, n_act;
    logic [9:0]  f0;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      dv[g] = 1'b0;
      tx_data[g] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_serial", 0, g_inst[0].o_serial, 1);
      check("idle_ready",  0, g_inst[0].o_ready,  1);
      check("idle_active", 0, g_inst[0].o_active, 0);
      check("idle_done",   0, g_inst[0].o_done,   0);
    end

    // One word into every configuration.
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      dv[g] = 1'b1;
      tx_data[g] = (g == 3) ? 9'h041 : 9'h0A5;
    end
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) dv[g] = 1'b0;
    @(posedge clk);
    f0 = {1'b1, 8'hA5, 1'b0};
    n_done = 0;
    k_done = -1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) check("start_latency", 0, g_inst[0].o_serial, 0);
      if (k < 40 && (k % 4) == 1) check("frame_bit", 0, g_inst[0].o_serial, f0[k/4]);
      if (g_inst[0].o_done) begin
        n_done++;
        k_done = k;
      end
      if (k == 40) check("active_fall", 0, g_inst[0].o_active, 0);
      if (k == 37) begin
        check("even_parity", 1, g_inst[1].o_serial, 0);
        check("odd_parity",  2, g_inst[2].o_serial, 1);
      end
      if (k == 25) check("odd_parity_7b", 3, g_inst[3].o_serial, 1);
    end
    check("done_count", 0, n_done, 1);
    check("done_cycle", 0, k_done + 1, 40);
    repeat (5) @(negedge clk);

    // Back-to-back with two stop bits, and a word offered while full.
    dv[2] = 1'b1;
    tx_data[2] = 9'h03C;
    @(posedge clk);
    @(negedge clk);
    dv[2] = 1'b0;
    @(posedge clk);
    n_done = 0;
    n_act  = 0;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      if (j == 0) begin
        dv[2] = 1'b1;
        tx_data[2] = 9'h0C3;
      end
      if (j == 1)  tx_data[2] = 9'h0FF;
      if (j == 31) dv[2] = 1'b0;
      if (j < 96 && !g_inst[2].o_active) n_act++;
      if (g_inst[2].o_done) n_done++;
      if (j == 47 || j == 95) check("b2b_done", 2, g_inst[2].o_done, 1);
      if (j == 48) check("b2b_start", 2, g_inst[2].o_serial, 0);
      if (j == 53) check("word2_d0", 2, g_inst[2].o_serial, 1);
      if (j == 61) check("word2_d2", 2, g_inst[2].o_serial, 0);
      if (j == 96) check("b2b_active_fall", 2, g_inst[2].o_active, 0);
    end
    check("b2b_active_gap", 2, n_act, 0);
    check("b2b_done_count", 2, n_done, 2);

    // Reset during data bit 3 with a word buffered.
    @(negedge clk);
    dv[0] = 1'b1;
    tx_data[0] = 9'h0A5;
    @(posedge clk);
    @(negedge clk);
    tx_data[0] = 9'h05A;
    @(posedge clk);
    n_done = 0;
    n_act  = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 0) check("drain_ready", 0, g_inst[0].o_ready, 1);
      if (j == 1) begin
        dv[0] = 1'b0;
        check("buffered_ready", 0, g_inst[0].o_ready, 0);
      end
      if (j == 17) rst = 1'b1;
      if (j == 18) begin
        rst = 1'b0;
        check("abort_serial", 0, g_inst[0].o_serial, 1);
        check("abort_active", 0, g_inst[0].o_active, 0);
        check("abort_ready",  0, g_inst[0].o_ready,  1);
      end
      if (g_inst[0].o_done) n_done++;
      if (j > 18 && g_inst[0].o_active) n_act++;
    end
    check("abort_no_resend", 0, n_act, 0);
    check("abort_no_done",   0, n_done, 0);

    // Randomized traffic, dense and sparse phases, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 1999) == 0);
      for (int g = 0; g < 4; g++) begin
        dv[g] = ($urandom_range(0, (((c / 500) % 2) == 0) ? 2 : 60) == 0);
        tx_data[g] = 9'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) dv[g] = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
